// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute sequencer driving PC load/increment, resolving jump, zero-branch and halt locally.
//   clk, rst (async active-low); pc_q current PC; mem_data/mem_ack instruction fetch return;
//   zero ALU flag; ex_done execution finished; mem_rd fetch request; pc_ld/pc_inc/pc_d PC controls;
//   ir instruction register; ex_start one-cycle execute pulse; halted sequencer stopped.
module pc_sequencer #(
  parameter int         W       = 16,
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [3:0] JMP_OP  = 4'hE,
  parameter logic [3:0] BRZ_OP  = 4'hD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pc_q,
  input  logic [W-1:0] mem_data,
  input  logic         mem_ack,
  input  logic         zero,
  input  logic         ex_done,
  output logic         mem_rd,
  output logic         pc_ld,
  output logic         pc_inc,
  output logic [W-1:0] pc_d,
  output logic [W-1:0] ir,
  output logic         ex_start,
  output logic         halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EX_START, EX_WAIT, INC, JUMP, HALT} state_t;
  state_t state, next;
  logic [3:0] op;
  assign op = ir[W-1 -: 4];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ir <= '0;
      pc_d <= '0;
    end else begin
      if (state == FETCH && mem_ack) ir <= mem_data;
      if (state == DECODE && op == JMP_OP) pc_d <= {{(W-12){1'b0}}, ir[11:0]};
      else if (state == DECODE && op == BRZ_OP && zero) pc_d <= pc_q + {{(W-12){ir[11]}}, ir[11:0]};
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = FETCH;
      FETCH:    next = mem_ack ? DECODE : FETCH;
      DECODE:   next = op == HALT_OP ? HALT :
                       op == JMP_OP  ? JUMP :
                       op == BRZ_OP  ? (zero ? JUMP : INC) : EX_START;
      EX_START: next = EX_WAIT;
      EX_WAIT:  next = ex_done ? INC : EX_WAIT;
      INC:      next = FETCH;
      JUMP:     next = FETCH;
      HALT:     next = HALT;
      default:  next = IDLE;
    endcase
  end
  assign mem_rd   = state == FETCH;
  assign pc_ld    = state == JUMP;
  assign pc_inc   = state == INC;
  assign ex_start = state == EX_START;
  assign halted   = state == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: instruction-level reference model expands each instruction into expected per-cycle records.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_q, mem_data, pc_d, ir, pc_init;
  logic        mem_ack, zero, ex_done, mem_rd, pc_ld, pc_inc, ex_start, halted;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        ack;
    logic [15:0] data;
    logic        z;
    logic        done;
    logic [4:0]  st;
    logic [15:0] ir;
    logic [15:0] pcd;
    logic [15:0] pc;
  } ent_t;
  ent_t        q[$];
  logic [15:0] m_ir, m_pcd, m_pc;

  localparam logic [4:0] S_NONE = 5'b00000, S_RD = 5'b10000, S_LD = 5'b01000,
                         S_INC = 5'b00100, S_EX = 5'b00010, S_HALT = 5'b00001;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .mem_data(mem_data), .mem_ack(mem_ack),
    .zero(zero), .ex_done(ex_done), .mem_rd(mem_rd), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_d(pc_d), .ir(ir), .ex_start(ex_start), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural PC register fed by the sequencer's strobes.
  always @(posedge clk or negedge rst)
    if (!rst) pc_q <= pc_init;
    else if (pc_ld) pc_q <= pc_d;
    else if (pc_inc) pc_q <= pc_q + 16'd1;

  task automatic chk(input string nm, input logic [4:0] st, input logic [15:0] eir, epcd, epc);
    logic [4:0] a;
    a = {mem_rd, pc_ld, pc_inc, ex_start, halted};
    checks++;
    if (a !== st || ir !== eir || pc_d !== epcd || pc_q !== epc) begin
      failures++;
      $display("FAIL %s: got rd/ld/inc/ex/halt=%b ir=%h pc_d=%h pc=%h, want %b %h %h %h",
               nm, a, ir, pc_d, pc_q, st, eir, epcd, epc);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic ack, input logic [15:0] data, input logic z, input logic done, input logic [4:0] st);
    q.push_back('{ack, data, z, done, st, m_ir, m_pcd, m_pc});
  endtask

  // Expand one instruction into the cycles it must take: w wait cycles before ack,
  // zf seen at decode, d cycles of ex_done low after ex_start.
  task automatic gen(input logic [15:0] ins, input int w, input logic zf, input int d);
    int off;
    repeat (w) push(1'b0, 16'($urandom), rb(), rb(), S_RD);
    push(1'b1, ins, rb(), rb(), S_RD);
    m_ir = ins;
    push(rb(), 16'($urandom), zf, rb(), S_NONE);
    off = ins[11] ? int'(ins[11:0]) - 4096 : int'(ins[11:0]);
    if (ins[15:12] == 4'hF) begin
      repeat (5) push(rb(), 16'($urandom), rb(), rb(), S_HALT);
    end else if (ins[15:12] == 4'hE || (ins[15:12] == 4'hD && zf)) begin
      m_pcd = ins[15:12] == 4'hE ? {4'h0, ins[11:0]} : 16'(int'(m_pc) + off);
      push(rb(), 16'($urandom), rb(), rb(), S_LD);
      m_pc = m_pcd;
    end else if (ins[15:12] == 4'hD) begin
      push(rb(), 16'($urandom), rb(), rb(), S_INC);
      m_pc = m_pc + 16'd1;
    end else begin
      push(rb(), 16'($urandom), rb(), rb(), S_EX);
      repeat (d) push(rb(), 16'($urandom), rb(), 1'b0, S_NONE);
      push(rb(), 16'($urandom), rb(), 1'b1, S_NONE);
      push(rb(), 16'($urandom), rb(), rb(), S_INC);
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic do_reset(input logic [15:0] pc0);
    pc_init = pc0;
    rst = 1'b0;
    {mem_ack, zero, ex_done} = 3'b000;
    mem_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset[%0d]", i), S_NONE, 16'h0, 16'h0, pc0);
    end
    rst = 1'b1;
    m_ir = '0;
    m_pcd = '0;
    m_pc = pc0;
  endtask

  task automatic run(input string nm);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, i), q[i].st, q[i].ir, q[i].pcd, q[i].pc);
      mem_ack = q[i].ack;
      mem_data = q[i].data;
      zero = q[i].z;
      ex_done = q[i].done;
    end
    q.delete();
  endtask

  initial begin
    pc_init = 16'h0002;
    {mem_ack, zero, ex_done} = 3'b000;
    mem_data = '0;
    #1;
    // Directed program: branch with wrap (taken then untaken), jump, ALU, long memory wait, halt.
    do_reset(16'h0002);
    gen(16'hDFFD, 0, 1'b1, 0);
    gen(16'hDFFD, 0, 1'b0, 0);
    gen(16'hE0A5, 0, 1'b0, 0);
    gen(16'h1234, 0, 1'b0, 2);
    gen(16'hF000, 5, 1'b0, 0);
    run("directed");
    // Reset in the middle of an execute wait.
    do_reset(16'h0010);
    @(negedge clk);
    chk("mid_fetch", S_RD, 16'h0, 16'h0, 16'h0010);
    mem_ack = 1'b1;
    mem_data = 16'h1234;
    @(negedge clk);
    chk("mid_decode", S_NONE, 16'h1234, 16'h0, 16'h0010);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("mid_exstart", S_EX, 16'h1234, 16'h0, 16'h0010);
    @(negedge clk);
    chk("mid_exwait", S_NONE, 16'h1234, 16'h0, 16'h0010);
    #2 rst = 1'b0;
    #1 chk("mid_async_rst", S_NONE, 16'h0, 16'h0, 16'h0010);
    @(negedge clk);
    chk("mid_rst_hold", S_NONE, 16'h0, 16'h0, 16'h0010);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_restart", S_RD, 16'h0, 16'h0, 16'h0010);
    // Random programs against the instruction-level model.
    for (int p = 0; p < 15; p++) begin
      do_reset(16'($urandom));
      for (int n = 0; n < int'($urandom_range(4, 14)); n++) begin
        int k;
        logic [15:0] ins;
        k = int'($urandom_range(0, 2));
        ins = k == 0 ? {4'($urandom_range(0, 12)), 12'($urandom)} :
              k == 1 ? {4'hE, 12'($urandom)} : {4'hD, 12'($urandom)};
        gen(ins, int'($urandom_range(0, 3)), rb(), int'($urandom_range(0, 3)));
      end
      gen({4'hF, 12'($urandom)}, int'($urandom_range(0, 3)), rb(), 0);
      run($sformatf("rand%0d", p));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-side counterpart of the program counter. Drives the PC's load/increment controls and load data, fetches instruction words, and sequences each instruction through fetch, decode and execute.
- Sits between instruction memory, the instruction register path, the CPU execution unit and the PC.
- Resolves jumps, zero-branches and halt locally. Hands all other opcodes to the execution unit through a start/done handshake.

Parameters:
- W, 16, data/address width; PC and instruction word width.
- HALT_OP, 4'hF, opcode value for halt.
- JMP_OP, 4'hE, opcode value for absolute jump.
- BRZ_OP, 4'hD, opcode value for PC-relative branch-if-zero.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-low.
- pc_q  input  W  current PC value (PC register output).
- mem_data  input  W  instruction word from memory.
- mem_ack  input  1  mem_data valid this cycle.
- zero  input  1  ALU zero flag.
- ex_done  input  1  execution unit finished the current instruction.
- mem_rd  output  1  instruction read request; memory address is pc_q.
- pc_ld  output  1  PC load strobe.
- pc_inc  output  1  PC increment strobe.
- pc_d  output  W  PC load value.
- ir  output  W  instruction register.
- ex_start  output  1  one-cycle start pulse to the execution unit.
- halted  output  1  sequencer stopped.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ir=0, pc_d=0; mem_rd, pc_ld, pc_inc, ex_start and halted all 0, effective immediately. This applies mid-operation in every state; any in-flight fetch or execute is abandoned.
- Outputs are Moore-decoded from the state register. pc_d and ir are registers.
- States and transitions:
  - IDLE: all strobes 0. Next cycle goes to FETCH unconditionally.
  - FETCH: mem_rd=1. On an edge with mem_ack=1: ir<=mem_data, go to DECODE. Otherwise stay, with no timeout.
  - DECODE: op=ir[15:12]. Decision is made on the clock edge.
    - op==HALT_OP: go to HALT.
    - op==JMP_OP: pc_d<={4'b0, ir[11:0]}, go to JUMP.
    - op==BRZ_OP and zero=1: pc_d<=pc_q+sext(ir[11:0]), go to JUMP. Addition is modulo 2^W; wrap-around is legal (e.g. 16'h0002 + (-3) = 16'hFFFF).
    - op==BRZ_OP and zero=0: go to INC.
    - Any other op: go to EX_START.
    - zero is sampled only on the DECODE edge.
  - EX_START: ex_start=1 for exactly one cycle, then go to EX_WAIT. ex_done is ignored in this cycle.
  - EX_WAIT: stay until ex_done=1, then go to INC.
  - INC: pc_inc=1 for exactly one cycle, then go to FETCH.
  - JUMP: pc_ld=1 for exactly one cycle with pc_d stable, then go to FETCH.
  - HALT: halted=1, and all other strobes 0 permanently. Only reset exits this state.
- Invariants:
  - pc_ld and pc_inc are never both 1.
  - At most one of mem_rd, ex_start, pc_ld, pc_inc is 1 in any cycle.
  - pc_d changes only on the DECODE edge.
  - ir changes only on a FETCH edge with mem_ack=1.
  - mem_ack outside FETCH is ignored. ex_done outside EX_WAIT is ignored.
- Latency, with zero-wait memory:
  - ALU instruction: 4 + (cycles until ex_done) from FETCH entry to the next FETCH (FETCH, DECODE, EX_START, EX_WAIT≥1, INC).
  - Jump/taken branch: 3 cycles.
  - Untaken branch: 3 cycles.
- The PC is updated by the PC block on the edge following the strobe. The next FETCH therefore sees the new pc_q.

Test Plan:
- Reset/startup: hold rst=0 for 3 cycles, then release → all outputs 0 during reset. 1 cycle after release, mem_rd=1.
- ALU instruction: mem_data=16'h1234 with mem_ack=1 on the first FETCH cycle, ex_done raised 3 cycles after ex_start → ir=16'h1234; ex_start high exactly 1 cycle; pc_inc high exactly 1 cycle, on the cycle after ex_done; pc_ld never high.
- Jump: fetch 16'hE0A5 → pc_d=16'h00A5 and pc_ld=1 exactly 1 cycle, 2 cycles after the ack edge; pc_inc stays 0; next state FETCH.
- Branch with wrap: pc_q=16'h0002, fetch 16'hDFFD. With zero=1 in DECODE → pc_ld=1, pc_d=16'hFFFF. Repeat with zero=0 → pc_inc=1, pc_ld=0.
- Memory wait and spurious handshakes: hold mem_ack=0 for 5 cycles while pulsing ex_done → mem_rd held 5+ cycles, ir unchanged, no state change. Then ack 16'hF000 → halted=1 permanently; further mem_ack/ex_done ignored.
- Reset mid-execute: assert rst=0 during EX_WAIT → ex_start, halted and ir clear immediately. After release, the sequence restarts at IDLE→FETCH.
